alu_seq: RTL and testbench

- Execute-stage sequencer directly upstream of the combinational ALU.
- Accepts decoded instructions over a valid/ready handshake and registers them.
- Drives the ALU's inst/arg1/arg2/acc inputs, then writes the ALU result back into the architectural accumulator.
- Emits accumulator values on an output handshake (OUT) and supports a HALT/restart cycle.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu.sv | 34 +++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, default widths and sequencer state type for the ALU and its sequencer.
package alu_pkg;

   localparam int ALU_W_DEF    = 11;
   localparam int ALU_OP_W_DEF = 4;

   localparam logic [ALU_OP_W_DEF-1:0] OP_NOP  = 4'd0;
   localparam logic [ALU_OP_W_DEF-1:0] OP_LDI  = 4'd1;
   localparam logic [ALU_OP_W_DEF-1:0] OP_OUT  = 4'd2;
   localparam logic [ALU_OP_W_DEF-1:0] OP_ADD  = 4'd5;
   localparam logic [ALU_OP_W_DEF-1:0] OP_SUB  = 4'd6;
   localparam logic [ALU_OP_W_DEF-1:0] OP_MUL  = 4'd7;
   localparam logic [ALU_OP_W_DEF-1:0] OP_NOT  = 4'd8;
   localparam logic [ALU_OP_W_DEF-1:0] OP_DGT  = 4'd9;
   localparam logic [ALU_OP_W_DEF-1:0] OP_DST  = 4'd10;
   localparam logic [ALU_OP_W_DEF-1:0] OP_HALT = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_EMIT,
      ST_HALTED
   } state_t;

   // Ops whose result comes from the ALU and is written into acc.
   function automatic logic is_alu_op(input logic [ALU_OP_W_DEF-1:0] op);
      return (op >= OP_ADD) && (op <= OP_DST);
   endfunction

   function automatic logic is_legal_op(input logic [ALU_OP_W_DEF-1:0] op);
      return (op == OP_NOP) || (op == OP_LDI) || (op == OP_OUT) ||
             (op == OP_HALT) || is_alu_op(op);
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; inst 0 (and any non-arithmetic opcode) passes acc through.
// Results wrap modulo 2^W.
module alu
   import alu_pkg::*;
#(
   parameter int W    = ALU_W_DEF,
   parameter int OP_W = ALU_OP_W_DEF
) (
   input  logic [OP_W-1:0] i_inst,
   input  logic [W-1:0]    i_arg1,
   input  logic [W-1:0]    i_arg2,
   input  logic [W-1:0]    i_acc,
   output logic [W-1:0]    o_out
);

   logic [W-1:0] w_dist;

   // DST is the unsigned distance between the two operands.
   assign w_dist = (i_arg1 >= i_arg2) ? (i_arg1 - i_arg2) : (i_arg2 - i_arg1);

   always_comb begin
      o_out = i_acc;
      case (i_inst)
         OP_ADD:  o_out = i_acc + i_arg1;
         OP_SUB:  o_out = i_acc - i_arg1;
         OP_MUL:  o_out = i_acc * i_arg1;
         OP_NOT:  o_out = ~i_acc;
         OP_DGT:  o_out = {{(W-1){1'b0}}, (i_acc > i_arg1)};
         OP_DST:  o_out = w_dist;
         default: o_out = i_acc;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage sequencer: IDLE->EXEC takes 2 cycles per instruction; OUT holds in EMIT until out_ready,
// HALT holds in HALTED until restart. ALU_SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W    = ALU_W_DEF,
   parameter int OP_W = ALU_OP_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [OP_W-1:0] instr_op,
   input  logic [W-1:0]    instr_arg1,
   input  logic [W-1:0]    instr_arg2,
   output logic [OP_W-1:0] alu_inst,
   output logic [W-1:0]    alu_arg1,
   output logic [W-1:0]    alu_arg2,
   output logic [W-1:0]    alu_acc,
   input  logic [W-1:0]    alu_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic [W-1:0]    acc,
   output logic            halted,
   output logic            illegal,
`ifdef ALU_SEQ_RETIRE_CNT_EN
   output logic [15:0]     retired,
`endif
   input  logic            restart
);

   state_t          r_state;
   state_t          w_next;
   logic [OP_W-1:0] r_op;
   logic [W-1:0]    r_arg1;
   logic [W-1:0]    r_arg2;
   logic [W-1:0]    r_acc;
   logic [W-1:0]    r_out_data;
   logic            r_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      instr_ready = 1'b0;
      out_valid   = 1'b0;
      halted      = 1'b0;
      alu_inst    = '0;
      case (r_state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) w_next = ST_EXEC;
         end
         ST_EXEC: begin
            alu_inst = r_op;
            if (r_op == OP_OUT)       w_next = ST_EMIT;
            else if (r_op == OP_HALT) w_next = ST_HALTED;
            else                      w_next = ST_IDLE;
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = ST_IDLE;
         end
         ST_HALTED: begin
            halted = 1'b1;
            if (restart) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Operand registers change only on acceptance, so they hold the last EXEC values elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op       <= '0;
         r_arg1     <= '0;
         r_arg2     <= '0;
         r_acc      <= '0;
         r_out_data <= '0;
         r_illegal  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && instr_valid) begin
            r_op   <= instr_op;
            r_arg1 <= instr_arg1;
            r_arg2 <= instr_arg2;
         end
         if (r_state == ST_EXEC) begin
            if (r_op == OP_LDI)          r_acc <= r_arg1;
            else if (is_alu_op(r_op))    r_acc <= alu_out;
            if (!is_legal_op(r_op))      r_illegal <= 1'b1;
            if (r_op == OP_OUT)          r_out_data <= r_acc;
         end
      end
   end

`ifdef ALU_SEQ_RETIRE_CNT_EN
   logic [15:0] r_retired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_retired <= '0;
      else if (r_state == ST_EXEC) r_retired <= r_retired + 16'd1;
   end

   assign retired = r_retired;
`endif

   assign alu_arg1 = r_arg1;
   assign alu_arg2 = r_arg2;
   assign alu_acc  = r_acc;
   assign acc      = r_acc;
   assign out_data = r_out_data;
   assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq driving the real alu; expected OUT words are queued at issue and popped by a monitor.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W    = 11;
   localparam int OP_W = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            instr_valid = 1'b0;
   logic            instr_ready;
   logic [OP_W-1:0] instr_op = '0;
   logic [W-1:0]    instr_arg1 = '0;
   logic [W-1:0]    instr_arg2 = '0;
   logic [OP_W-1:0] alu_inst;
   logic [W-1:0]    alu_arg1;
   logic [W-1:0]    alu_arg2;
   logic [W-1:0]    alu_acc;
   logic [W-1:0]    alu_out;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [W-1:0]    out_data;
   logic [W-1:0]    acc;
   logic            halted;
   logic            illegal;
   logic            restart = 1'b0;
`ifdef ALU_SEQ_RETIRE_CNT_EN
   logic [15:0]     retired;
`endif

   int           n_checks  = 0;
   int           n_errors  = 0;
   int           n_retired = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   alu_seq #(.W(W), .OP_W(OP_W)) u_dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_arg1(instr_arg1), .instr_arg2(instr_arg2),
      .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
      .alu_acc(alu_acc), .alu_out(alu_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .acc(acc), .halted(halted), .illegal(illegal),
`ifdef ALU_SEQ_RETIRE_CNT_EN
      .retired(retired),
`endif
      .restart(restart)
   );

   alu #(.W(W), .OP_W(OP_W)) u_alu (
      .i_inst(alu_inst), .i_arg1(alu_arg1), .i_arg2(alu_arg2),
      .i_acc(alu_acc), .o_out(alu_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction when ready; returns #1 after the accepting edge (DUT now in EXEC).
   task automatic issue(input logic [OP_W-1:0] op, input logic [W-1:0] a1, input logic [W-1:0] a2);
      int wait_cyc = 0;
      while (!instr_ready && wait_cyc < 20) begin
         step();
         wait_cyc++;
      end
      if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 1);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_arg1  = a1;
      instr_arg2  = a2;
      step();
      instr_valid = 1'b0;
      n_retired++;
   endtask

   task automatic exec(input logic [OP_W-1:0] op, input logic [W-1:0] a1, input logic [W-1:0] a2);
      issue(op, a1, a2);
      step();
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL out_unexpected: got %0d expected no word", out_data);
            end else begin
               chk("out_data", 32'(out_data), 32'(exp_q[0]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         monitor();
      join_none

      @(posedge clk);
      @(negedge clk);
      chk("rst_acc", 32'(acc), 0);
      chk("rst_alu_acc", 32'(alu_acc), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_alu_inst", 32'(alu_inst), 0);
      chk("rst_alu_arg1", 32'(alu_arg1), 0);
      chk("rst_alu_arg2", 32'(alu_arg2), 0);
      chk("rst_ready", 32'(instr_ready), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      step();

      // LDI 100; ADD 23 with per-cycle handshake checks
      issue(OP_LDI, 11'd100, 11'd0);
      chk("exec_ready", 32'(instr_ready), 0);
      chk("exec_alu_inst", 32'(alu_inst), 1);
      chk("exec_alu_arg1", 32'(alu_arg1), 100);
      chk("exec_acc_old", 32'(acc), 0);
      step();
      chk("ldi_acc", 32'(acc), 100);
      chk("idle_ready", 32'(instr_ready), 1);
      chk("idle_alu_inst", 32'(alu_inst), 0);
      chk("idle_arg1_hold", 32'(alu_arg1), 100);
      issue(OP_ADD, 11'd23, 11'd0);
      chk("add_exec_alu_acc", 32'(alu_acc), 100);
      chk("add_exec_alu_out", 32'(alu_out), 123);
      step();
      chk("add_acc", 32'(acc), 123);
      chk("add_alu_acc", 32'(alu_acc), 123);

      // Wrap and other ALU ops
      exec(OP_LDI, 11'd2047, 11'd0);
      exec(OP_ADD, 11'd1, 11'd0);
      chk("add_wrap", 32'(acc), 0);
      exec(OP_NOT, 11'd0, 11'd0);
      chk("not_acc", 32'(acc), 2047);
      exec(OP_LDI, 11'd10, 11'd0);
      exec(OP_MUL, 11'd3, 11'd0);
      chk("mul_acc", 32'(acc), 30);
      exec(OP_SUB, 11'd35, 11'd0);
      chk("sub_wrap", 32'(acc), 2043);
      exec(OP_DST, 11'd5, 11'd12);
      chk("dst_acc", 32'(acc), 7);
      chk("arg2_hold", 32'(alu_arg2), 12);
      exec(OP_DGT, 11'd6, 11'd0);
      chk("dgt_acc", 32'(acc), 1);

      // OUT with stalled consumer
      exec(OP_LDI, 11'd42, 11'd0);
      out_ready = 1'b0;
      exp_q.push_back(11'd42);
      issue(OP_OUT, 11'd0, 11'd0);
      chk("out_exec_valid", 32'(out_valid), 0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("emit_valid", 32'(out_valid), 1);
         chk("emit_ready", 32'(instr_ready), 0);
         if (i < 4) step();
      end
      out_ready = 1'b1;
      step();
      chk("emit_done_valid", 32'(out_valid), 0);
      chk("emit_done_ready", 32'(instr_ready), 1);
      chk("out_q_drained", 32'(exp_q.size()), 0);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_idle_halted", 32'(halted), 0);
      chk("restart_idle_ready", 32'(instr_ready), 1);

      // Illegal opcode
      exec(4'd12, 11'd5, 11'd0);
      chk("illegal_acc", 32'(acc), 42);
      chk("illegal_flag", 32'(illegal), 1);
      exec(OP_ADD, 11'd8, 11'd0);
      chk("post_illegal_add", 32'(acc), 50);
      chk("illegal_sticky", 32'(illegal), 1);

      // HALT and restart
      issue(OP_HALT, 11'd0, 11'd0);
      step();
      chk("halted", 32'(halted), 1);
      chk("halted_ready", 32'(instr_ready), 0);
      chk("halted_acc", 32'(acc), 50);
      instr_valid = 1'b1;
      instr_op    = OP_LDI;
      instr_arg1  = 11'd99;
      repeat (3) step();
      chk("halted_ignore_acc", 32'(acc), 50);
      chk("halted_stay", 32'(halted), 1);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("restart_halted", 32'(halted), 0);
      chk("restart_ready", 32'(instr_ready), 1);
      chk("restart_acc", 32'(acc), 50);
      step();
      instr_valid = 1'b0;
      n_retired++;
      chk("accept_after_restart", 32'(instr_ready), 0);
      chk("accept_alu_inst", 32'(alu_inst), 1);
      step();
      chk("ldi_after_restart", 32'(acc), 99);

      // Reset during EMIT
      exec(OP_LDI, 11'd77, 11'd0);
      out_ready = 1'b0;
      exp_q.push_back(11'd77);
      issue(OP_OUT, 11'd0, 11'd0);
      step();
      chk("emit77_valid", 32'(out_valid), 1);
      chk("emit77_data", 32'(out_data), 77);
`ifdef ALU_SEQ_RETIRE_CNT_EN
      chk("retired_count", 32'(retired), 32'(n_retired[15:0]));
`endif
      rst = 1'b1;
      #1;
      chk("rst_emit_valid", 32'(out_valid), 0);
      chk("rst_emit_acc", 32'(acc), 0);
      chk("rst_emit_ready", 32'(instr_ready), 1);
      chk("rst_emit_illegal", 32'(illegal), 0);
      chk("rst_emit_out_data", 32'(out_data), 0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
      chk("rst_retired", 32'(retired), 0);
`endif
      exp_q.delete();
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      exec(OP_LDI, 11'd5, 11'd0);
      chk("post_rst_ldi", 32'(acc), 5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
